// File: rtl/d_latch_exerciser_if.sv
// Control and latch-drive bundle for d_latch_exerciser.
// i_* are driven toward the exerciser, o_* are driven by it.
//   i_start     : one-cycle run request
//   i_q         : output of the latch under test
//   o_d         : data drive to the latch
//   o_enable    : enable drive to the latch
//   o_busy      : run in progress
//   o_done      : run finished, held until the next start or reset
//   o_err_count : saturating mismatch count
//   o_pass      : done and no mismatches
interface d_latch_exerciser_if #(
  parameter int unsigned ERR_W = 8
);
  logic             i_start;
  logic             i_q;
  logic             o_d;
  logic             o_enable;
  logic             o_busy;
  logic             o_done;
  logic [ERR_W-1:0] o_err_count;
  logic             o_pass;

  modport master (
    output i_start, i_q,
    input  o_d, o_enable, o_busy, o_done, o_err_count, o_pass
  );

  modport slave (
    input  i_start, i_q,
    output o_d, o_enable, o_busy, o_done, o_err_count, o_pass
  );
endinterface

// File: rtl/d_latch_exerciser.sv
// Clocked stimulus driver and checker for a level-sensitive D latch.
// Holds enable low for IDLE_CYC cycles, opens it for EN_CYC cycles, then
// closes it again, while d toggles every TOGGLE_CYC cycles. q is compared
// every cycle of the check window against a reference hold register.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : control/latch bundle (slave side), see d_latch_exerciser_if
module d_latch_exerciser #(
  parameter int unsigned TOGGLE_CYC  = 10,
  parameter int unsigned IDLE_CYC    = 100,
  parameter int unsigned EN_CYC      = 100,
  parameter int unsigned NUM_TOGGLES = 50,
  parameter int unsigned ERR_W       = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  d_latch_exerciser_if.slave    bus
);

  localparam int unsigned TOG_SPAN = TOGGLE_CYC * NUM_TOGGLES;
  localparam int unsigned EN_END   = IDLE_CYC + EN_CYC;
  localparam int unsigned END_K    = (TOG_SPAN > EN_END) ? TOG_SPAN : EN_END;
  localparam int unsigned K_W      = $clog2(END_K + 1);
  localparam int unsigned PH_W     = (TOGGLE_CYC > 2) ? $clog2(TOGGLE_CYC) : 1;
  localparam int unsigned TG_W     = $clog2(NUM_TOGGLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [K_W-1:0]   r_k;
  logic [PH_W-1:0]  r_ph;     // r_k mod TOGGLE_CYC
  logic [TG_W-1:0]  r_tog;    // toggles issued so far
  logic             r_d;
  logic             r_en;
  logic             r_qm;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;

  logic [K_W-1:0]   w_k_nxt;
  logic             w_en_nxt;
  logic             w_tog;
  logic             w_chk;
  logic             w_ref;
  logic             w_mis;
  logic             w_last;
  logic [ERR_W-1:0] w_err_nxt;

  // Outputs are registered one cycle ahead, so decode for cycle k+1.
  assign w_k_nxt  = r_k + 1'b1;
  assign w_en_nxt = (w_k_nxt >= K_W'(IDLE_CYC)) && (w_k_nxt < K_W'(EN_END));
  assign w_tog    = (r_ph == PH_W'(TOGGLE_CYC/2 - 1)) && (r_tog < TG_W'(NUM_TOGGLES));
  assign w_last   = (r_k == K_W'(END_K - 1));

  // Transparent: q follows d. Opaque: q holds the last transparent d.
  assign w_chk     = (r_k >= K_W'(IDLE_CYC));
  assign w_ref     = r_en ? r_d : r_qm;
  assign w_mis     = (bus.i_q === w_ref) ? 1'b0 : 1'b1;
  assign w_err_nxt = (w_chk && w_mis && (r_err != '1)) ? r_err + 1'b1 : r_err;

  // Sequencer, reference model and checker.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_ph    <= '0;
      r_tog   <= '0;
      r_d     <= 1'b0;
      r_en    <= 1'b0;
      r_qm    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            r_state <= S_RUN;
            r_k     <= '0;
            r_ph    <= '0;
            r_tog   <= '0;
            r_d     <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
          end
        end
        S_RUN: begin
          r_err <= w_err_nxt;
          if (r_en) r_qm <= r_d;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
            r_en    <= 1'b0;
          end else begin
            r_k  <= w_k_nxt;
            r_ph <= (r_ph == PH_W'(TOGGLE_CYC - 1)) ? '0 : r_ph + 1'b1;
            r_en <= w_en_nxt;
            if (w_tog) begin
              r_d   <= ~r_d;
              r_tog <= r_tog + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_d         = r_d;
  assign bus.o_enable    = r_en;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_err_count = r_err;
  assign bus.o_pass      = r_pass;

endmodule

// File: tb/tb_d_latch_exerciser.sv
// Directed bench for d_latch_exerciser: table of latch-fault modes with
// hand-computed error counts, plus mid-run start and mid-run reset sequences.
module tb_d_latch_exerciser;

  localparam int T    = 10;
  localparam int IDLE = 100;
  localparam int EN   = 100;
  localparam int NT   = 50;
  localparam int ENDK = 500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   q_mode = 0;    // 0 latch, 1 stuck-0, 2 q=d, 3 stuck-1
  logic lq = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  d_latch_exerciser_if #(.ERR_W(8)) bus ();
  d_latch_exerciser_if #(.ERR_W(4)) bus2 ();

  d_latch_exerciser #(
    .TOGGLE_CYC(T), .IDLE_CYC(IDLE), .EN_CYC(EN), .NUM_TOGGLES(NT), .ERR_W(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave)
  );

  d_latch_exerciser #(
    .TOGGLE_CYC(T), .IDLE_CYC(IDLE), .EN_CYC(EN), .NUM_TOGGLES(NT), .ERR_W(4)
  ) dut4 (
    .i_clk(clk), .i_rst(rst), .bus(bus2.slave)
  );

  // Behavioural latch under test.
  always_latch begin
    if (bus.o_enable) lq = bus.o_d;
  end

  assign bus.i_start  = start;
  assign bus.i_q      = (q_mode == 0) ? lq :
                        (q_mode == 1) ? 1'b0 :
                        (q_mode == 2) ? bus.o_d : 1'b1;
  assign bus2.i_start = start;
  assign bus2.i_q     = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_d_at(input int c);
    int t;
    if (c < T/2) t = 0;
    else t = (c - T/2) / T + 1;
    if (t > NT) t = NT;
    return t % 2;
  endfunction

  function automatic int exp_en_at(input int c);
    return (c >= IDLE && c < IDLE + EN) ? 1 : 0;
  endfunction

  // One run: pulse start, follow it cycle by cycle, check the end state.
  // mid_k >= 0 pulses start again at that cycle; rst_k >= 0 resets there.
  task automatic run_one(input int mode, input int exp_err, input int exp_pass,
                         input int mid_k, input int rst_k);
    int c;
    int bad;
    q_mode = mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", int'(bus.o_busy), 1);
    check("start_done", int'(bus.o_done), 0);
    check("start_err",  int'(bus.o_err_count), 0);
    check("start_pass", int'(bus.o_pass), 0);
    c = 0;
    bad = 0;
    while (bus.o_busy && c < ENDK + 100) begin
      if (int'(bus.o_d) != exp_d_at(c) || int'(bus.o_enable) != exp_en_at(c)) bad++;
      start = (c == mid_k);
      if (c == rst_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_done", int'(bus.o_done), 0);
        check("rst_d",    int'(bus.o_d), 0);
        check("rst_en",   int'(bus.o_enable), 0);
        check("rst_err",  int'(bus.o_err_count), 0);
        check("rst_pass", int'(bus.o_pass), 0);
        check("rst_pattern_bad_cycles", bad, 0);
        return;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check("busy_cycles", c, ENDK);
    check("pattern_bad_cycles", bad, 0);
    check("end_done", int'(bus.o_done), 1);
    check("end_err",  int'(bus.o_err_count), exp_err);
    check("end_pass", int'(bus.o_pass), exp_pass);
    check("end_en",   int'(bus.o_enable), 0);
    check("end_d",    int'(bus.o_d), 0);
    repeat (3) @(negedge clk);
    check("done_held", int'(bus.o_done), 1);
    check("err_held",  int'(bus.o_err_count), exp_err);
  endtask

  typedef struct {
    int mode;
    int exp_err;
    int exp_pass;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 0, 1};     // good latch
    vecs[1] = '{1, 50, 0};    // stuck-0: d=1 for 5x10 cycles in the window
    vecs[2] = '{2, 150, 0};   // no hold: 15x10 d=1 cycles after the window
    vecs[3] = '{3, 255, 0};   // stuck-1: 50 + 300 = 350, saturates
    vecs[4] = '{0, 0, 1};     // start from DONE clears the count

    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.o_busy), 0);
    check("reset_done", int'(bus.o_done), 0);
    check("reset_d",    int'(bus.o_d), 0);
    check("reset_en",   int'(bus.o_enable), 0);
    check("reset_err",  int'(bus.o_err_count), 0);
    check("reset_pass", int'(bus.o_pass), 0);
    // start together with rst: rst wins
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_under_rst_busy", int'(bus.o_busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(bus.o_busy), 0);

    for (int i = 0; i < 5; i++) begin
      run_one(vecs[i].mode, vecs[i].exp_err, vecs[i].exp_pass, -1, -1);
      check("w4_err_sat", int'(bus2.o_err_count), 15);
      check("w4_pass",    int'(bus2.o_pass), 0);
      check("w4_done",    int'(bus2.o_done), 1);
    end

    // start pulsed mid-run is ignored; END unchanged
    run_one(0, 0, 1, 30, -1);

    // reset mid-run, then a full clean run
    run_one(1, 0, 0, -1, 150);
    @(negedge clk);
    check("post_rst_idle_busy", int'(bus.o_busy), 0);
    run_one(0, 0, 1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
